// File: rtl/key_pad_emulator_pkg.sv
// Shared keypad definitions: key-to-matrix table, FSM states and idle constants.
// The state set includes BOUNCE only when KP_EMU_BOUNCE_EN is defined.
package key_pad_emulator_pkg;

  localparam logic [3:0] ROW_NONE = 4'b1111;
  localparam logic [3:0] COL_NONE = 4'b1111;

`ifdef KP_EMU_BOUNCE_EN
  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} kp_state_e;
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} kp_state_e;
`endif

  // Returns {row, col}, both one-cold; the scanner decodes with this same table.
  function automatic logic [7:0] key_rc(input logic [3:0] key);
    logic [7:0] rc;
    case (key)
      4'h7: rc = {4'b1110, 4'b1110};
      4'h4: rc = {4'b1110, 4'b1101};
      4'h1: rc = {4'b1110, 4'b1011};
      4'h0: rc = {4'b1110, 4'b0111};
      4'h8: rc = {4'b1101, 4'b1110};
      4'h5: rc = {4'b1101, 4'b1101};
      4'h2: rc = {4'b1101, 4'b1011};
      4'hA: rc = {4'b1101, 4'b0111};
      4'h9: rc = {4'b1011, 4'b1110};
      4'h6: rc = {4'b1011, 4'b1101};
      4'h3: rc = {4'b1011, 4'b1011};
      4'hB: rc = {4'b1011, 4'b0111};
      4'hC: rc = {4'b0111, 4'b1110};
      4'hD: rc = {4'b0111, 4'b1101};
      4'hE: rc = {4'b0111, 4'b1011};
      default: rc = {4'b0111, 4'b0111};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_pad_emulator_req_fifo.sv
// Request queue of {key, hold}: first-word fall-through FIFO with full/empty/count.
module kp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_pad_emulator.sv
// Keypad column emulator: replays queued key presses onto the 4x4 matrix.
// Optional contact chatter before each press is enabled with KP_EMU_BOUNCE_EN.
module key_pad_emulator
  import key_pad_emulator_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_TICKS  = 4
`ifdef KP_EMU_BOUNCE_EN
  , parameter int BOUNCE_TICKS = 6
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  input  logic [7:0] req_hold,
  output logic       req_ready,
  output logic       key_active,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS);
`ifdef KP_EMU_BOUNCE_EN
  localparam logic [7:0] BOUNCE_LOAD = 8'(BOUNCE_TICKS);
`endif

  kp_state_e     state;
  logic [7:0]    cnt;
  logic [3:0]    cur_key;
  logic          press;
  logic [7:0]    cur_rc;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [11:0]   head;
  logic [7:0]    head_hold;
`ifdef KP_EMU_BOUNCE_EN
  logic [7:0]    hold_r;
`endif

  kp_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(12)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({req_key, req_hold}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign head_hold = (head[7:0] == 8'd0) ? 8'd1 : head[7:0];
  // The last gap tick doubles as the idle pop, so back-to-back presses are exactly GAP_TICKS apart.
  assign pop       = !fifo_empty && ((state == IDLE) || (state == GAP && cnt == 8'd1));
  assign cur_rc    = key_rc(cur_key);

  always_comb begin
    kp_col = COL_NONE;
    if (press && kp_row == cur_rc[7:4]) kp_col = cur_rc[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cur_key    <= 4'd0;
      press      <= 1'b0;
      key_active <= 1'b0;
`ifdef KP_EMU_BOUNCE_EN
      hold_r     <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: ;
`ifdef KP_EMU_BOUNCE_EN
        BOUNCE: begin
          if (cnt == 8'd1) begin
            state <= HOLD;
            cnt   <= hold_r;
            press <= 1'b1;
          end else begin
            cnt   <= cnt - 8'd1;
            press <= !press;
          end
        end
`endif
        HOLD: begin
          if (cnt == 8'd1) begin
            state      <= GAP;
            cnt        <= GAP_LOAD;
            press      <= 1'b0;
            key_active <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd1) state <= IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
      // Starting a press overrides whatever the case above scheduled.
      if (pop) begin
        cur_key    <= head[11:8];
        press      <= 1'b1;
        key_active <= 1'b1;
`ifdef KP_EMU_BOUNCE_EN
        state      <= BOUNCE;
        cnt        <= BOUNCE_LOAD;
        hold_r     <= head_hold;
`else
        state      <= HOLD;
        cnt        <= head_hold;
`endif
      end
    end
  end

endmodule
